// File: rtl/fifo_wr_arbiter_if.sv
// Handshake bundle between the producers, the write arbiter and the FIFO write port.
// The master modport is the arbiter's view. The slave modport is the view of the producers and FIFO.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic [NUM_REQ-1:0]            req_drop;
    logic                          fifo_wr_en;
    logic [FIFO_WIDTH-1:0]         fifo_data_in;
    logic                          fifo_wr_ack;
    logic                          fifo_overflow;
    logic                          fifo_full;
    logic [ID_W-1:0]               grant_id;
    logic                          busy;

    modport master (
        input  req_valid, req_data, fifo_wr_ack, fifo_overflow, fifo_full,
        output req_ready, req_drop, fifo_wr_en, fifo_data_in, grant_id, busy
    );

    modport slave (
        output req_valid, req_data, fifo_wr_ack, fifo_overflow, fifo_full,
        input  req_ready, req_drop, fifo_wr_en, fifo_data_in, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares one FIFO write port among NUM_REQ producers.
// It keeps one write outstanding at a time and retries rejected words up to MAX_RETRY attempts.
module fifo_wr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned FIFO_WIDTH = 16,
    parameter int unsigned MAX_RETRY  = 4,
    parameter int unsigned ID_W       = $clog2(NUM_REQ)
) (
    input logic               clk,
    input logic               rst_n,
    fifo_wr_arbiter_if.master bus
);
    localparam int unsigned TRY_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StRetry} state_e;

    state_e                 state_q, state_d;
    logic [ID_W-1:0]        grant_q, grant_d;
    logic [ID_W-1:0]        last_q, last_d;
    logic [FIFO_WIDTH-1:0]  data_q, data_d;
    logic [TRY_W-1:0]       try_q, try_d;
    logic [NUM_REQ-1:0]     ready_q, ready_d;
    logic [NUM_REQ-1:0]     drop_q, drop_d;

    logic                   pick_found;
    logic [ID_W-1:0]        pick_id;
    logic [ID_W-1:0]        cand;

    // Search from the requester after the last one served, wrapping around.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand       = '0;
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = ID_W'((32'(last_q) + k) % NUM_REQ);
            if (!pick_found && bus.req_valid[cand]) begin
                pick_found = 1'b1;
                pick_id    = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        last_d  = last_q;
        data_d  = data_q;
        try_d   = try_q;
        ready_d = '0;
        drop_d  = '0;
        case (state_q)
            StIdle: begin
                if (pick_found && !bus.fifo_full) begin
                    grant_d = pick_id;
                    data_d  = bus.req_data[32'(pick_id) * FIFO_WIDTH +: FIFO_WIDTH];
                    try_d   = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                try_d   = try_q + 1'b1;
                state_d = StWait;
            end
            StWait: begin
                // An ack wins even if overflow is also raised.
                if (bus.fifo_wr_ack) begin
                    ready_d[grant_q] = 1'b1;
                    last_d           = grant_q;
                    state_d          = StIdle;
                end else if (try_q == TRY_W'(MAX_RETRY)) begin
                    drop_d[grant_q] = 1'b1;
                    last_d          = grant_q;
                    state_d         = StIdle;
                end else begin
                    state_d = StRetry;
                end
            end
            StRetry: begin
                if (!bus.fifo_full) begin
                    state_d = StIssue;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            grant_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            data_q  <= '0;
            try_q   <= '0;
            ready_q <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            data_q  <= data_d;
            try_q   <= try_d;
            ready_q <= ready_d;
            drop_q  <= drop_d;
        end
    end

    assign bus.busy         = (state_q != StIdle);
    assign bus.fifo_wr_en   = (state_q == StIssue);
    assign bus.fifo_data_in = (state_q != StIdle) ? data_q : '0;
    assign bus.grant_id     = grant_q;
    assign bus.req_ready    = ready_q;
    assign bus.req_drop     = drop_q;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios followed by randomized transactions.
// The reference model works at word level and is built from the round-robin and retry rules.
module tb_fifo_wr_arbiter;
    localparam int unsigned NUM_REQ    = 4;
    localparam int unsigned FIFO_WIDTH = 16;
    localparam int unsigned MAX_RETRY  = 4;
    localparam int unsigned ID_W       = $clog2(NUM_REQ);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fifo_wr_arbiter_if #(.NUM_REQ(NUM_REQ), .FIFO_WIDTH(FIFO_WIDTH), .ID_W(ID_W)) bus ();

    fifo_wr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .FIFO_WIDTH(FIFO_WIDTH),
        .MAX_RETRY (MAX_RETRY),
        .ID_W      (ID_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    logic [FIFO_WIDTH-1:0] word [NUM_REQ];
    logic [NUM_REQ-1:0]    vld;
    int                    model_last;
    int                    errors = 0;
    int                    checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        bus.req_valid = vld;
        for (int i = 0; i < NUM_REQ; i++) bus.req_data[i*FIFO_WIDTH +: FIFO_WIDTH] = word[i];
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input int last, input logic [NUM_REQ-1:0] v);
        for (int k = 1; k <= NUM_REQ; k++) begin
            if (v[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
        end
        return -1;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
        check({tag, "_data"}, 32'(bus.fifo_data_in), 0);
        check({tag, "_ready"}, 32'(bus.req_ready), 0);
        check({tag, "_drop"}, 32'(bus.req_drop), 0);
        check({tag, "_gid"}, 32'(bus.grant_id), 0);
        check({tag, "_busy"}, 32'(bus.busy), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        vld = '0;
        for (int i = 0; i < NUM_REQ; i++) word[i] = '0;
        drive();
        bus.fifo_wr_ack = 1'b0;
        bus.fifo_overflow = 1'b0;
        bus.fifo_full = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
    endtask

    // Called in an idle cycle with inputs already driven; returns after the ready/drop pulse
    // cycle, having updated the served requester's inputs for that same cycle.
    task automatic run_txn(input int n_ovf, input bit rnd, input bit refill,
                           output int got_gid, output int n_wr);
        int w, att, k;
        bit done, ack, ovf;
        int unsigned r;
        logic [FIFO_WIDTH-1:0] lat;
        w = rr_pick(model_last, vld);
        lat = word[w];
        n_wr = 0;
        att = 0;
        done = 1'b0;
        step();
        got_gid = int'(bus.grant_id);
        while (!done) begin
            check("issue_wr_en", 32'(bus.fifo_wr_en), 1);
            check("issue_data", 32'(bus.fifo_data_in), 32'(lat));
            check("issue_gid", 32'(bus.grant_id), w);
            check("issue_busy", 32'(bus.busy), 1);
            check("issue_nopulse", 32'({bus.req_ready, bus.req_drop}), 0);
            if (bus.fifo_wr_en === 1'b1) n_wr++;
            att++;
            step();
            check("wait_wr_en", 32'(bus.fifo_wr_en), 0);
            check("wait_data", 32'(bus.fifo_data_in), 32'(lat));
            check("wait_busy", 32'(bus.busy), 1);
            // A requester may withdraw after grant; the latched word must still go out.
            if (rnd && $urandom_range(0, 5) == 0) begin
                vld[w] = 1'b0;
                word[w] = FIFO_WIDTH'($urandom);
                drive();
            end
            if (rnd) begin
                r = $urandom_range(0, 9);
                ack = (r < 4) || (r == 9);
                ovf = (r >= 4 && r < 8) || (r == 9);
            end else begin
                ack = (att > n_ovf);
                ovf = !ack;
            end
            bus.fifo_wr_ack = ack;
            bus.fifo_overflow = ovf;
            step();
            bus.fifo_wr_ack = 1'b0;
            bus.fifo_overflow = 1'b0;
            if (ack) begin
                check("ready_pulse", 32'(bus.req_ready), 32'(1) << w);
                check("ready_nodrop", 32'(bus.req_drop), 0);
                check("ready_busy", 32'(bus.busy), 0);
                done = 1'b1;
            end else if (att == MAX_RETRY) begin
                check("drop_pulse", 32'(bus.req_drop), 32'(1) << w);
                check("drop_noready", 32'(bus.req_ready), 0);
                check("drop_busy", 32'(bus.busy), 0);
                done = 1'b1;
            end else begin
                check("retry_busy", 32'(bus.busy), 1);
                check("retry_wr_en", 32'(bus.fifo_wr_en), 0);
                check("retry_nopulse", 32'({bus.req_ready, bus.req_drop}), 0);
                k = rnd ? $urandom_range(0, 2) : 0;
                if (k > 0) begin
                    bus.fifo_full = 1'b1;
                    repeat (k) begin
                        step();
                        check("retry_full_wr_en", 32'(bus.fifo_wr_en), 0);
                        check("retry_full_busy", 32'(bus.busy), 1);
                    end
                    bus.fifo_full = 1'b0;
                end
                step();
            end
        end
        model_last = w;
        if (rnd) refill = 1'($urandom_range(0, 1));
        vld[w] = refill;
        word[w] = FIFO_WIDTH'($urandom);
        if (rnd) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!vld[i] && $urandom_range(0, 2) == 0) begin
                    vld[i] = 1'b1;
                    word[i] = FIFO_WIDTH'($urandom);
                end
            end
            if (vld == '0) vld[$urandom_range(0, NUM_REQ - 1)] = 1'b1;
        end
        drive();
    endtask

    initial begin
        int g, n, k;
        do_reset();

        // Single requester accepted.
        vld = 4'b0100;
        word[2] = 16'hA5A5;
        drive();
        run_txn(0, 1'b0, 1'b0, g, n);
        check("single_gid", 32'(g), 2);
        check("single_nwr", 32'(n), 1);
        step();
        check("single_ready_once", 32'(bus.req_ready), 0);
        check("single_idle_busy", 32'(bus.busy), 0);
        check("single_idle_data", 32'(bus.fifo_data_in), 0);

        // Round robin with everybody requesting.
        do_reset();
        vld = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) word[i] = FIFO_WIDTH'(16'h1000 + i);
        drive();
        for (int i = 0; i < 5; i++) begin
            run_txn(0, 1'b0, 1'b1, g, n);
            check("rr_order", 32'(g), 32'(i % 4));
        end

        // Full back-pressure in idle.
        do_reset();
        vld = 4'b0010;
        word[1] = 16'h5A5A;
        drive();
        bus.fifo_full = 1'b1;
        repeat (10) begin
            step();
            check("full_wr_en", 32'(bus.fifo_wr_en), 0);
            check("full_busy", 32'(bus.busy), 0);
        end
        bus.fifo_full = 1'b0;
        run_txn(0, 1'b0, 1'b0, g, n);
        check("full_gid", 32'(g), 1);

        // Two overflows then ack.
        do_reset();
        vld = 4'b0001;
        word[0] = 16'hC3C3;
        drive();
        run_txn(2, 1'b0, 1'b0, g, n);
        check("retry_nwr", 32'(n), 3);

        // Overflow on every attempt, then the next requester is served.
        do_reset();
        vld = 4'b0011;
        word[0] = 16'h1111;
        word[1] = 16'h2222;
        drive();
        run_txn(MAX_RETRY, 1'b0, 1'b0, g, n);
        check("drop_gid", 32'(g), 0);
        check("drop_nwr", 32'(n), MAX_RETRY);
        run_txn(0, 1'b0, 1'b0, g, n);
        check("after_drop_gid", 32'(g), 1);

        // Reset while waiting for the FIFO response.
        do_reset();
        vld = 4'b1111;
        for (int i = 0; i < NUM_REQ; i++) word[i] = FIFO_WIDTH'(16'h7000 + i);
        drive();
        step();
        check("mid_issue_gid", 32'(bus.grant_id), 0);
        step();
        check("mid_wait_busy", 32'(bus.busy), 1);
        vld = 4'b0110;
        drive();
        bus.fifo_wr_ack = 1'b1;
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_async");
        step();
        bus.fifo_wr_ack = 1'b0;
        step();
        check_all_zero("mid_held");
        vld = 4'b1111;
        drive();
        rst_n = 1'b1;
        model_last = NUM_REQ - 1;
        run_txn(0, 1'b0, 1'b1, g, n);
        check("mid_restart_gid", 32'(g), 0);

        // Randomized traffic.
        do_reset();
        for (int i = 0; i < NUM_REQ; i++) word[i] = FIFO_WIDTH'($urandom);
        vld = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
        drive();
        for (int t = 0; t < 200; t++) begin
            k = $urandom_range(0, 3);
            if (t % 3 == 0 && k > 0) begin
                bus.fifo_full = 1'b1;
                repeat (k) begin
                    step();
                    check("rnd_full_wr_en", 32'(bus.fifo_wr_en), 0);
                    check("rnd_full_busy", 32'(bus.busy), 0);
                end
                bus.fifo_full = 1'b0;
            end
            run_txn(0, 1'b1, 1'b0, g, n);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Round-robin write-port arbiter that shares one synchronous FIFO write port among `NUM_REQ` producers. Each granted word gets exactly one FIFO write attempt at a time. The arbiter confirms each attempt through the FIFO's `wr_ack`/`overflow` response and retries rejected words up to a bounded count. It sits between the producer blocks and the FIFO's DUT-side write port (`wr_en`, `data_in`, `wr_ack`, `overflow`, `full`).

## Interface
- `NUM_REQ`, 4: number of requesters, ≥2.
- `FIFO_WIDTH`, 16: data word width; matches the FIFO.
- `MAX_RETRY`, 4: maximum write attempts per word before it is dropped, ≥1.
- `ID_W`, $clog2(NUM_REQ): width of `grant_id`.

Ports:
- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NUM_REQ: requester i has a word pending.
- `req_data` in NUM_REQ*FIFO_WIDTH: requester i's word at `[i*FIFO_WIDTH +: FIFO_WIDTH]`.
- `req_ready` out NUM_REQ: one-cycle one-hot pulse; word written successfully.
- `req_drop` out NUM_REQ: one-cycle one-hot pulse; word discarded after `MAX_RETRY` rejections.
- `fifo_wr_en` out 1: FIFO write strobe.
- `fifo_data_in` out FIFO_WIDTH: FIFO write data.
- `fifo_wr_ack` in 1: FIFO accepted the previous-cycle write.
- `fifo_overflow` in 1: FIFO rejected the previous-cycle write.
- `fifo_full` in 1: FIFO full flag.
- `grant_id` out ID_W: index of the current grantee; valid while `busy`.
- `busy` out 1: state ≠ IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, RETRY.
- **IDLE**
  - If any `req_valid` and `!fifo_full`, select the first set bit searching from `last_grant+1` (wrapping modulo `NUM_REQ`).
  - Latch its index into `grant_id` and its word into the data register, clear `try_cnt`, then go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE**
  - Drive `fifo_wr_en`=1 for exactly this cycle, with `fifo_data_in` = latched word.
  - Increment `try_cnt`, then go to WAIT.
- **WAIT**: samples the FIFO response, which is registered and arrives exactly one cycle after `wr_en`.
  - `fifo_wr_ack`=1: pulse `req_ready[grant_id]` next cycle, set `last_grant`=`grant_id`, go to IDLE.
  - Otherwise (`fifo_overflow`, or neither flag): if `try_cnt`==`MAX_RETRY`, pulse `req_drop[grant_id]` next cycle, set `last_grant`=`grant_id`, go to IDLE; else go to RETRY.
  - `wr_ack` and `overflow` both set is illegal; `wr_ack` takes precedence.
- **RETRY**: hold grant and data; go to ISSUE once `fifo_full`=0.
- **Requester protocol**
  - Requesters keep `req_valid` and data stable until their `req_ready` or `req_drop`.
  - The word is latched at grant, so deasserting `req_valid` after grant does not cancel the transfer.
  - Requesters sample `req_ready` and `req_drop` as one-cycle pulses.
- Data is never modified; `fifo_data_in` holds the latched word in all states and is 0 in IDLE.
- `last_grant` resets to `NUM_REQ-1`, so requester 0 wins first. It advances only on ready or drop, never on retry.

## Timing
- Reset values:
  - Outputs: `fifo_wr_en`=0, `fifo_data_in`=0, `req_ready`=0, `req_drop`=0, `grant_id`=0, `busy`=0.
  - Internal: state IDLE, `try_cnt`=0.
- Reset mid-operation:
  - All outputs clear immediately (asynchronously).
  - The in-flight word is lost; no ready or drop pulse is produced.
  - After release, arbitration restarts from requester 0.
- Best-case latency: `req_valid` sampled at edge 0, `fifo_wr_en` high in cycle 1, ack sampled at edge 2, `req_ready` high in cycle 2→3 (the IDLE cycle).
- Throughput: at most one FIFO write per 3 cycles. Only one write is ever outstanding, so the arbiter cannot cause back-to-back overflow.
- `req_ready` and `req_drop` are registered and never assert in the same cycle.
- `fifo_full` is checked only in IDLE and RETRY, never in ISSUE.

## Test plan
- **Single requester, accepted**: `req_valid`=4'b0100, `req_data[2]`=16'hA5A5, FIFO empty, ack returned → one `fifo_wr_en` pulse carrying 16'hA5A5 in cycle 1; `req_ready`=4'b0100 for one cycle in cycle 3; `grant_id`=2 while `busy`.
- **Round robin**: all four `req_valid` held high, every write acked → grant order 0,1,2,3,0; `fifo_wr_en` pulses spaced 3 cycles apart.
- **Full back-pressure**: `fifo_full`=1 for 10 cycles with `req_valid[1]`=1 → no `fifo_wr_en`, `busy`=0; after `fifo_full` drops → write issued on the next cycle (IDLE→ISSUE).
- **Retry then success**: two `fifo_overflow` responses, then ack → three `fifo_wr_en` pulses with identical data; one `req_ready` pulse; no `req_drop`.
- **Drop**: `MAX_RETRY`=4 and overflow on every attempt → exactly four `fifo_wr_en` pulses, then one `req_drop` pulse; the next grant goes to the following requester.
- **Reset mid-operation**: `rst_n` low during WAIT → all outputs 0 immediately, no ready or drop; after release, with all requesting, requester 0 is granted first.
